// File: rtl/vram_port_sched.sv
// Single-port frame VRAM access scheduler: scanout reads, fill engine and host writes,
// with scanout at strict priority. Sole driver of the RAM address, data and write enable.
module vram_port_sched #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 22500
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(DEPTH);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nx;
    logic [DATA_W-1:0] clr_color_q, clr_color_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_nx;
    logic              wren_nx, done_nx, err_nx;
    logic              rd_p1, rd_p2, oor_p1, oor_p2;

    assign wr_ready = RST_N & (state == IDLE) & ~rd_req & ~clr_start;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    // clr_addr reaching DEPTH marks the cycle after the last fill write; finishing
    // there puts clr_done in the cycle after the final ram_wren cycle.
    always_comb begin
        state_nx     = state;
        clr_addr_nx  = clr_addr;
        clr_color_nx = clr_color_q;
        addr_nx      = ram_address;
        data_nx      = ram_data;
        wren_nx      = 1'b0;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        if (rd_req) addr_nx = rd_addr;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    clr_color_nx = clr_color;
                    clr_addr_nx  = '0;
                    state_nx     = CLEAR;
                end else if (wr_valid && !rd_req) begin
                    if (wr_addr < END_ADDR) begin
                        addr_nx = wr_addr;
                        data_nx = wr_data;
                        wren_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (clr_addr == END_ADDR) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (!rd_req) begin
                    addr_nx     = clr_addr;
                    data_nx     = clr_color_q;
                    wren_nx     = 1'b1;
                    clr_addr_nx = clr_addr + ADDR_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clr_addr    <= '0;
            clr_color_q <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            wr_err      <= 1'b0;
            rd_p1       <= 1'b0;
            rd_p2       <= 1'b0;
            oor_p1      <= 1'b0;
            oor_p2      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            clr_addr    <= clr_addr_nx;
            clr_color_q <= clr_color_nx;
            ram_address <= addr_nx;
            ram_data    <= data_nx;
            ram_wren    <= wren_nx;
            clr_busy    <= (state_nx == CLEAR);
            clr_done    <= done_nx;
            wr_err      <= err_nx;
            // Read pipeline: issue, RAM address register, data capture.
            rd_p1       <= rd_req;
            oor_p1      <= rd_req && (rd_addr >= END_ADDR);
            rd_p2       <= rd_p1;
            oor_p2      <= oor_p1;
            rd_valid    <= rd_p2;
            if (rd_p2) rd_data <= oor_p2 ? '0 : ram_q;
        end
    end

endmodule

// File: tb/tb_vram_port_sched.sv
// Directed bench for vram_port_sched with a behavioural synchronous-read RAM attached.
`timescale 1ns/1ps
module tb_vram_port_sched;

    localparam int DEPTH = 22500;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        rd_req = 1'b0;
    logic [14:0] rd_addr = '0;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic        wr_valid = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ready, wr_err;
    logic        clr_start = 1'b0;
    logic [11:0] clr_color = '0;
    logic        clr_busy, clr_done;
    logic [14:0] ram_address;
    logic [11:0] ram_data;
    logic        ram_wren;
    logic [11:0] ram_q = '0;

    vram_port_sched #(.ADDR_W(15), .DATA_W(12), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 CLK = ~CLK;

    // Out-of-range locations hold a non-zero pattern so forced-zero reads are visible.
    logic [11:0] mem [0:32767] = '{default: 12'hEEE};
    int unsigned hits [0:32767] = '{default: 0};
    int unsigned hits0 [0:32767];
    int unsigned wren_total = 0;

    always @(posedge CLK) begin
        if (ram_wren) begin
            mem[ram_address]  <= ram_data;
            hits[ram_address] <= hits[ram_address] + 1;
            wren_total        <= wren_total + 1;
        end
        ram_q <= mem[ram_address];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_chk(input logic [14:0] a, input logic [11:0] exp, input string nm);
        rd_req = 1'b0;
        repeat (4) step();
        rd_req = 1'b1; rd_addr = a;
        step();
        rd_req = 1'b0;
        chk({nm, " valid@E1"}, rd_valid, 0);
        step();
        chk({nm, " valid@E2"}, rd_valid, 0);
        step();
        chk({nm, " valid@E3"}, rd_valid, 1);
        chk({nm, " data@E3"}, rd_data, exp);
        step();
        chk({nm, " valid@E4"}, rd_valid, 0);
    endtask

    typedef struct {
        logic        rd;
        logic [14:0] ra;
        logic        wv;
        logic [14:0] wa;
        logic [11:0] wd;
        logic        e_ready;
        logic        e_wren;
        logic        chk_a;
        logic [14:0] e_addr;
        logic [11:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int bad, cyc, done_cnt, done_cyc, last_wren;
        int unsigned w0;

        vecs[0] = '{1'b0, 15'd0,     1'b0, 15'd0,     12'h000, 1'b1, 1'b0, 1'b0, 15'd0,     12'h000, 1'b0};
        vecs[1] = '{1'b0, 15'd0,     1'b1, 15'd100,   12'hABC, 1'b1, 1'b1, 1'b1, 15'd100,   12'hABC, 1'b0};
        vecs[2] = '{1'b0, 15'd0,     1'b1, 15'd22499, 12'h123, 1'b1, 1'b1, 1'b1, 15'd22499, 12'h123, 1'b0};
        vecs[3] = '{1'b0, 15'd0,     1'b1, 15'd22500, 12'h555, 1'b1, 1'b0, 1'b1, 15'd22499, 12'h000, 1'b1};
        vecs[4] = '{1'b0, 15'd0,     1'b1, 15'd32767, 12'h777, 1'b1, 1'b0, 1'b1, 15'd22499, 12'h000, 1'b1};
        vecs[5] = '{1'b1, 15'd200,   1'b1, 15'd300,   12'h666, 1'b0, 1'b0, 1'b1, 15'd200,   12'h000, 1'b0};
        vecs[6] = '{1'b1, 15'd32767, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 1'b1, 15'd32767, 12'h000, 1'b0};
        vecs[7] = '{1'b0, 15'd0,     1'b1, 15'd0,     12'h0FF, 1'b1, 1'b1, 1'b1, 15'd0,     12'h0FF, 1'b0};

        // Reset held with requests active
        RST_N = 1'b0; rd_req = 1'b1; rd_addr = 15'd5; wr_valid = 1'b1; wr_addr = 15'd3; wr_data = 12'h001;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (wr_ready !== 1'b0) bad++;
            step();
            if (ram_wren !== 1'b0) bad++;
        end
        chk("reset wr_ready/wren", bad, 0);
        chk("reset ram_address", ram_address, 0);
        chk("reset ram_data", ram_data, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset clr_busy", clr_busy, 0);
        chk("reset clr_done", clr_done, 0);
        chk("reset wr_err", wr_err, 0);
        RST_N = 1'b1; rd_req = 1'b0; wr_valid = 1'b0;
        step();

        // Single-cycle IDLE behaviour table
        for (int i = 0; i < 8; i++) begin
            rd_req = vecs[i].rd; rd_addr = vecs[i].ra;
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d wr_ready", i), wr_ready, vecs[i].e_ready);
            step();
            chk($sformatf("vec%0d ram_wren", i), ram_wren, vecs[i].e_wren);
            if (vecs[i].chk_a) chk($sformatf("vec%0d ram_address", i), ram_address, vecs[i].e_addr);
            if (vecs[i].e_wren) chk($sformatf("vec%0d ram_data", i), ram_data, vecs[i].e_data);
            chk($sformatf("vec%0d wr_err", i), wr_err, vecs[i].e_err);
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        step();

        read_chk(15'd100,   12'hABC, "rd 100");
        read_chk(15'd22499, 12'h123, "rd 22499");
        read_chk(15'd22500, 12'h000, "rd 22500");
        read_chk(15'd32767, 12'h000, "rd 32767");

        // Back-to-back reads
        repeat (4) step();
        rd_req = 1'b1; rd_addr = 15'd100;   step();
        rd_addr = 15'd22499;                step();
        rd_addr = 15'd0;                    step();
        rd_req = 1'b0;
        chk("pipe0 valid", rd_valid, 1); chk("pipe0 data", rd_data, 12'hABC);
        step();
        chk("pipe1 valid", rd_valid, 1); chk("pipe1 data", rd_data, 12'h123);
        step();
        chk("pipe2 valid", rd_valid, 1); chk("pipe2 data", rd_data, 12'h0FF);
        step();
        chk("pipe end valid", rd_valid, 0);

        // Contention: scanout holds off the host write
        rd_req = 1'b1; rd_addr = 15'd50; wr_valid = 1'b1; wr_addr = 15'd400; wr_data = 12'h5A5;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wr_ready !== 1'b0) bad++;
            step();
            if (ram_wren !== 1'b0) bad++;
        end
        chk("contention blocked", bad, 0);
        rd_req = 1'b0;
        #1;
        chk("contention ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        chk("contention wren", ram_wren, 1);
        chk("contention addr", ram_address, 400);
        chk("contention data", ram_data, 12'h5A5);
        step();
        chk("contention single wren", ram_wren, 0);
        read_chk(15'd400, 12'h5A5, "rd 400");

        // Fill under 50% scanout, with a host write pending and a second clr_start
        for (int a = 0; a < 32768; a++) hits0[a] = hits[a];
        w0 = wren_total;
        clr_color = 12'hF00; clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 15'd9; wr_data = 12'h333;
        #1;
        chk("clr_start wr_ready", wr_ready, 0);
        step();
        clr_start = 1'b0;
        chk("clr busy rises", clr_busy, 1);
        chk("clr first cycle no wren", ram_wren, 0);
        cyc = 0; done_cnt = 0; done_cyc = -1; last_wren = -1; bad = 0;
        while (cyc < 60000 && !(done_cnt > 0 && cyc > done_cyc + 5)) begin
            if (ram_wren) last_wren = cyc;
            if (clr_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                wr_valid = 1'b0;
            end
            rd_req = cyc[0]; rd_addr = 15'd7;
            clr_start = (cyc == 5000);
            clr_color = (cyc == 5000) ? 12'h0F0 : 12'hF00;
            #1;
            if (clr_busy && wr_ready !== 1'b0) bad++;
            step();
            cyc++;
        end
        rd_req = 1'b0; clr_start = 1'b0; wr_valid = 1'b0;
        chk("clr finished in budget", done_cyc >= 0, 1);
        chk("clr_done pulse count", done_cnt, 1);
        chk("clr_done after last wren", done_cyc, last_wren + 1);
        chk("clr wr_ready held low", bad, 0);
        chk("clr wren total", wren_total - w0, DEPTH);
        bad = 0;
        for (int a = 0; a < 32768; a++)
            if (hits[a] - hits0[a] != ((a < DEPTH) ? 1 : 0)) bad++;
        chk("clr address coverage", bad, 0);
        chk("clr busy falls", clr_busy, 0);
        read_chk(15'd0,     12'hF00, "rd fill 0");
        read_chk(15'd11250, 12'hF00, "rd fill 11250");
        read_chk(15'd22499, 12'hF00, "rd fill 22499");
        read_chk(15'd400,   12'hF00, "rd fill 400");

        // Reset mid-fill, with a read in flight
        clr_color = 12'h0AA; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (1000) step();
        chk("midclr busy", clr_busy, 1);
        chk("midclr addr", ram_address, 999);
        rd_req = 1'b1; rd_addr = 15'd100;
        step();
        rd_req = 1'b0; RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("abort busy", clr_busy, 0);
        chk("abort done", clr_done, 0);
        chk("abort rd_valid", rd_valid, 0);
        chk("abort wren", ram_wren, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (clr_done !== 1'b0 || rd_valid !== 1'b0 || ram_wren !== 1'b0) bad++;
        end
        chk("abort quiet", bad, 0);
        clr_color = 12'h0BB; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("restart busy", clr_busy, 1);
        step();
        chk("restart wren", ram_wren, 1);
        chk("restart addr0", ram_address, 0);
        chk("restart data", ram_data, 12'h0BB);
        step();
        chk("restart addr1", ram_address, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
